// File: rtl/read_responder.sv
// Register-file read responder: fixed-latency read pipeline with range checking,
// plus a write port that loads the storage.
module read_responder #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           write_en,
  input  logic [ADDR_WIDTH-1:0]          write_addr,
  input  logic [WIDTH-1:0]               write_data,
  input  logic                           read_req,
  input  logic [ADDR_WIDTH-1:0]          read_addr,
  output logic [WIDTH-1:0]               read_data,
  output logic                           read_valid,
  output logic                           read_err,
  output logic [$clog2(LATENCY+1)-1:0]   pending
);

  localparam int IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW = $clog2(LATENCY + 1);
  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] err_q;
  logic [WIDTH-1:0]   dat_q [LATENCY];
  logic [CntW-1:0]    pending_q, pending_d;

  logic              wr_hit, rd_hit;
  logic [IdxW-1:0]   wr_idx, rd_idx;
  logic [WIDTH-1:0]  rd_word;

  assign wr_hit = write_en && ({1'b0, write_addr} < DepthLim);
  assign rd_hit = {1'b0, read_addr} < DepthLim;
  assign wr_idx = write_addr[IdxW-1:0];
  assign rd_idx = read_addr[IdxW-1:0];

  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      rd_word = mem_q[rd_idx];
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (read_req && !read_valid) begin
      pending_d = pending_q + CntW'(1);
    end else if (!read_req && read_valid) begin
      pending_d = pending_q - CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q     <= '0;
      err_q     <= '0;
      pending_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= read_req;
      err_q[0] <= read_req && !rd_hit;
      if (read_req) begin
        dat_q[0] <= rd_word;
      end
      // Data only advances behind a valid entry, so the output word holds between responses.
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
      if (wr_hit) begin
        mem_q[wr_idx] <= write_data;
      end
      pending_q <= pending_d;
    end
  end

  assign read_data  = dat_q[LATENCY-1];
  assign read_valid = vld_q[LATENCY-1];
  assign read_err   = err_q[LATENCY-1];
  assign pending    = pending_q;

endmodule
